// File: rtl/hsl_to_rgb_pipe_pkg.sv
// hsl_pkg: shared constants, sector enum and stage payload structs for the
// HSL -> RGB pipeline.
package hsl_pkg;

  localparam int HUE_MAX       = 360;
  localparam int SECTOR_DEG    = 60;
  localparam int RECIP60       = 17477;  // 2^20 / 60, exact for y <= 15330
  localparam int RECIP60_SHIFT = 20;
  localparam int H_W           = 9;
  localparam int C_W           = 8;

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4,
    S5 = 3'd5
  } sector_t;

  // Stage 1 -> stage 2 payload
  typedef struct packed {
    sector_t     sector;
    logic [5:0]  f;
    logic [15:0] cn;
    logic [7:0]  l;
  } s1_t;

  // Stage 2 -> stage 3 payload
  typedef struct packed {
    sector_t        sector;
    logic [C_W-1:0] c;
    logic [5:0]     gp;
    logic [7:0]     m;
  } s2_t;

  // Add the lightness offset to a component, clamping at 255.
  function automatic logic [7:0] add_sat8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[8] ? 8'hff : sum[7:0];
  endfunction

endpackage

// File: rtl/hsl_to_rgb_pipe_hue_sector_split.sv
// hue_sector_split: splits a wrapped hue (0..359) into its 60-degree sector
// and the offset inside that sector, using a compare chain instead of a divider.
module hue_sector_split
  import hsl_pkg::*;
(
  input  logic [H_W-1:0] he_i,
  output sector_t        sector_o,
  output logic [5:0]     f_o
);

  logic [H_W-1:0] base;

  // Highest sector boundary not above the hue wins; offset is the remainder.
  always_comb begin
    sector_o = S0;
    base     = '0;
    if (he_i >= H_W'(5 * SECTOR_DEG)) begin
      sector_o = S5;
      base     = H_W'(5 * SECTOR_DEG);
    end else if (he_i >= H_W'(4 * SECTOR_DEG)) begin
      sector_o = S4;
      base     = H_W'(4 * SECTOR_DEG);
    end else if (he_i >= H_W'(3 * SECTOR_DEG)) begin
      sector_o = S3;
      base     = H_W'(3 * SECTOR_DEG);
    end else if (he_i >= H_W'(2 * SECTOR_DEG)) begin
      sector_o = S2;
      base     = H_W'(2 * SECTOR_DEG);
    end else if (he_i >= H_W'(SECTOR_DEG)) begin
      sector_o = S1;
      base     = H_W'(SECTOR_DEG);
    end
    f_o = 6'(he_i - base);
  end

endmodule

// File: rtl/hsl_to_rgb_pipe.sv
// hsl_to_rgb_pipe: 3-stage HSL -> RGB converter with valid/ready on both sides.
// One pixel per clock; a global enable freezes every stage while the output
// is held by downstream backpressure.
// Optional build macro HSL2RGB_RANGE_CHECK_EN: hue >= 360 blanks the pixel to
// black and raises herr_o alongside it instead of wrapping the hue.
module hsl_to_rgb_pipe
  import hsl_pkg::*;
#(
  parameter int ROUND_C = 1
)
(
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           in_valid_i,
  output logic           in_ready_o,
  input  logic [H_W-1:0] h_i,
  input  logic [7:0]     s_i,
  input  logic [7:0]     l_i,
  output logic           out_valid_o,
  input  logic           out_ready_i,
  output logic [7:0]     r_o,
  output logic [7:0]     g_o,
  output logic [7:0]     b_o
`ifdef HSL2RGB_RANGE_CHECK_EN
  ,
  output logic           herr_o
`endif
);

  localparam int STAGES = 3;

  logic              en;
  logic [STAGES:1]   vld_pipe_q;
  logic [STAGES:1]   vld_pipe_d;

  // The whole pipe moves only when the output slot is free or being drained.
  assign en          = !(vld_pipe_q[STAGES] && !out_ready_i);
  assign in_ready_o  = en;
  assign out_valid_o = vld_pipe_q[STAGES];
  assign vld_pipe_d  = {vld_pipe_q[STAGES-1:1], in_valid_i};

  // Valid shift register; bubbles travel with the data and are never squeezed out.
  always_ff @(posedge clk_i) begin
    if (rst_i)   vld_pipe_q <= '0;
    else if (en) vld_pipe_q <= vld_pipe_d;
  end

  // ---------------- Stage 1: hue wrap, sector split, chroma numerator
  logic [H_W-1:0] he;
  logic [8:0]     l2;
  logic [7:0]     d;
  sector_t        sec1;
  logic [5:0]     f1;
  s1_t            s1_d, s1_q;

  assign he = (h_i >= H_W'(HUE_MAX)) ? h_i - H_W'(HUE_MAX) : h_i;
  assign l2 = {l_i, 1'b0};
  assign d  = (l2 >= 9'd255) ? 8'(l2 - 9'd255) : 8'(9'd255 - l2);

  hue_sector_split u_split (
    .he_i     (he),
    .sector_o (sec1),
    .f_o      (f1)
  );

  assign s1_d.sector = sec1;
  assign s1_d.f      = f1;
  assign s1_d.cn     = 16'(8'd255 - d) * 16'(s_i);
  assign s1_d.l      = l_i;

  // Stage 1 register: capture only real pixels so stale data never leaks forward.
  always_ff @(posedge clk_i) begin
    if (rst_i)                   s1_q <= '0;
    else if (en && vld_pipe_d[1]) s1_q <= s1_d;
  end

  // ---------------- Stage 2: chroma, ramp direction, lightness offset
  logic [15:0]    c_num;
  logic [C_W-1:0] c2;
  s2_t            s2_d, s2_q;

  assign c_num = (ROUND_C != 0) ? s1_q.cn + 16'd127 : s1_q.cn;
  assign c2    = C_W'(c_num / 16'd255);

  assign s2_d.sector = s1_q.sector;
  assign s2_d.c      = c2;
  // Even sectors ramp up from their start edge, odd sectors ramp down.
  assign s2_d.gp     = s1_q.sector[0] ? 6'd60 - s1_q.f : s1_q.f;
  assign s2_d.m      = (s1_q.l >= (c2 >> 1)) ? s1_q.l - (c2 >> 1) : 8'd0;

  // Stage 2 register
  always_ff @(posedge clk_i) begin
    if (rst_i)                   s2_q <= '0;
    else if (en && vld_pipe_d[2]) s2_q <= s2_d;
  end

  // ---------------- Stage 3: secondary component, sector map, offset add
  logic [13:0] xprod;
  logic [31:0] xscaled;
  logic [7:0]  x3;
  logic [7:0]  rp, gp, bp;
  logic [7:0]  r_d, g_d, b_d;

  // Rounded C*g'/60 via reciprocal multiply; exact over the whole operand range.
  assign xprod   = 14'(s2_q.c) * 14'(s2_q.gp) + 14'd30;
  assign xscaled = (32'(xprod) * 32'(RECIP60)) >> RECIP60_SHIFT;
  assign x3      = xscaled[7:0];

  // Place C and X into the channels that own them for this sector.
  always_comb begin
    rp = '0;
    gp = '0;
    bp = '0;
    case (s2_q.sector)
      S0:      begin rp = s2_q.c; gp = x3;             end
      S1:      begin rp = x3;     gp = s2_q.c;         end
      S2:      begin gp = s2_q.c; bp = x3;             end
      S3:      begin gp = x3;     bp = s2_q.c;         end
      S4:      begin rp = x3;     bp = s2_q.c;         end
      S5:      begin rp = s2_q.c; bp = x3;             end
      default: begin rp = '0;     gp = '0;     bp = '0; end
    endcase
    r_d = add_sat8(rp, s2_q.m);
    g_d = add_sat8(gp, s2_q.m);
    b_d = add_sat8(bp, s2_q.m);
  end

`ifdef HSL2RGB_RANGE_CHECK_EN
  logic herr1_q, herr2_q, herr3_q;

  // Out-of-range flag rides alongside the pixel through every stage.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      herr1_q <= 1'b0;
      herr2_q <= 1'b0;
      herr3_q <= 1'b0;
    end else if (en) begin
      if (vld_pipe_d[1]) herr1_q <= (h_i >= H_W'(HUE_MAX));
      if (vld_pipe_d[2]) herr2_q <= herr1_q;
      if (vld_pipe_d[3]) herr3_q <= herr2_q;
    end
  end

  assign herr_o = herr3_q;
`endif

  logic [7:0] r_q, g_q, b_q;

  // Output register; a flagged pixel is blanked to black.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_q <= '0;
      g_q <= '0;
      b_q <= '0;
    end else if (en && vld_pipe_d[3]) begin
`ifdef HSL2RGB_RANGE_CHECK_EN
      r_q <= herr2_q ? 8'd0 : r_d;
      g_q <= herr2_q ? 8'd0 : g_d;
      b_q <= herr2_q ? 8'd0 : b_d;
`else
      r_q <= r_d;
      g_q <= g_d;
      b_q <= b_d;
`endif
    end
  end

  assign r_o = r_q;
  assign g_o = g_q;
  assign b_o = b_q;

endmodule
